// File: rtl/step_pulse_gen_pkg.sv
// ============================================================================
// step_pulse_gen_pkg : FSM state encoding and default timing constants
// Revision 1.0
// ============================================================================
`default_nettype none

package step_pulse_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_DB_PRESS   = 2'd1,
    ST_HELD       = 2'd2,
    ST_DB_RELEASE = 2'd3
  } state_e;

  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_REPEAT_DELAY    = 64;
  localparam int DEF_REPEAT_PERIOD   = 16;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync2.sv
// ============================================================================
// sync2 : two-flop synchronizer for a single asynchronous level
// Revision 1.0
// ============================================================================
`default_nettype none

module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

`default_nettype wire

// File: rtl/step_pulse_gen.sv
// ============================================================================
// step_pulse_gen : debounced push-button to one-cycle step pulse, auto-repeat
// Revision 1.0
// ============================================================================
`default_nettype none

module step_pulse_gen
  import step_pulse_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  input  logic repeat_en,
  output logic step,
  output logic held
);

  localparam int TW = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) + 1;

  localparam logic [TW-1:0] DB_LAST   = TW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] RPT_FIRST = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] RPT_NEXT  = TW'(REPEAT_PERIOD - 1);

  generate
    if (REPEAT_PERIOD < 2 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1) begin : g_bad_params
      $error("step_pulse_gen: REPEAT_PERIOD must be >= 2, DEBOUNCE_CYCLES and REPEAT_DELAY >= 1");
    end
  endgenerate

  function automatic logic [TW-1:0] inc_sat(input logic [TW-1:0] v);
    return (v == {TW{1'b1}}) ? v : v + 1'b1;
  endfunction

  logic          btn_s;
  state_e        state_q, state_d;
  logic [TW-1:0] db_cnt_q, db_cnt_d;
  logic [TW-1:0] rpt_cnt_q, rpt_cnt_d;
  logic          rpt_run_q, rpt_run_d;
  logic          step_q, step_d;
  logic          held_q, held_d;

  sync2 u_btn_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn),
    .q     (btn_s)
  );

  always_comb begin
    state_d   = state_q;
    db_cnt_d  = db_cnt_q;
    rpt_cnt_d = rpt_cnt_q;
    rpt_run_d = rpt_run_q;
    step_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        db_cnt_d  = '0;
        rpt_cnt_d = '0;
        rpt_run_d = 1'b0;
        if (btn_s) state_d = ST_DB_PRESS;
      end
      ST_DB_PRESS: begin
        if (!btn_s) begin
          state_d = ST_IDLE;
        end else if (db_cnt_q == DB_LAST) begin
          state_d   = ST_HELD;
          step_d    = 1'b1;
          rpt_cnt_d = '0;
          rpt_run_d = 1'b0;
        end else begin
          db_cnt_d = inc_sat(db_cnt_q);
        end
      end
      ST_HELD: begin
        // rpt_run_q selects the period target once the initial delay has fired
        if (!btn_s) begin
          state_d  = ST_DB_RELEASE;
          db_cnt_d = '0;
        end else if (!repeat_en) begin
          rpt_cnt_d = '0;
          rpt_run_d = 1'b0;
        end else if (rpt_cnt_q == (rpt_run_q ? RPT_NEXT : RPT_FIRST)) begin
          step_d    = 1'b1;
          rpt_cnt_d = '0;
          rpt_run_d = 1'b1;
        end else begin
          rpt_cnt_d = inc_sat(rpt_cnt_q);
        end
      end
      ST_DB_RELEASE: begin
        if (btn_s) begin
          state_d   = ST_HELD;
          rpt_cnt_d = '0;
          rpt_run_d = 1'b0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d = ST_IDLE;
        end else begin
          db_cnt_d = inc_sat(db_cnt_q);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    held_d = (state_d == ST_HELD) || (state_d == ST_DB_RELEASE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      db_cnt_q  <= '0;
      rpt_cnt_q <= '0;
      rpt_run_q <= 1'b0;
      step_q    <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      db_cnt_q  <= db_cnt_d;
      rpt_cnt_q <= rpt_cnt_d;
      rpt_run_q <= rpt_run_d;
      step_q    <= step_d;
      held_q    <= held_d;
    end
  end

  assign step = step_q;
  assign held = held_q;

endmodule

`default_nettype wire

// File: tb/tb_step_pulse_gen.sv
// ============================================================================
// tb_step_pulse_gen : scoreboard bench for step_pulse_gen
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_step_pulse_gen;

  localparam int D  = 16;
  localparam int RD = 64;
  localparam int RP = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn = 1'b0;
  logic repeat_en = 1'b0;
  logic step;
  logic held;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int step_cnt = 0;
  int sbq[$];
  bit exp_held = 1'b0;

  // reference model: btn_s is btn delayed two edges; acceptance flips after
  // D+1 consecutive opposite samples; repeats counted by hold age
  bit m_s1, m_s2, m_prev, m_acc;
  int m_run, m_age;

  always #5 clk = ~clk;

  step_pulse_gen #(
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn       (btn),
    .repeat_en (repeat_en),
    .step      (step),
    .held      (held)
  );

  task automatic model_edge();
    bit bs;
    bit accepted_now;
    cyc++;
    if (!reset) begin
      m_s1 = 0; m_s2 = 0; m_prev = 0; m_acc = 0;
      m_run = 0; m_age = 0;
      sbq.delete();
    end else begin
      bs = m_s2;
      m_s2 = m_s1;
      m_s1 = btn;
      accepted_now = 0;
      if (bs != m_acc) begin
        m_run++;
        if (m_run == D + 1) begin
          m_acc = bs;
          m_run = 0;
          accepted_now = bs;
        end
      end else begin
        m_run = 0;
      end
      if (accepted_now) begin
        sbq.push_back(cyc);
        m_age = 0;
      end else if (m_acc && bs && m_prev && repeat_en) begin
        m_age++;
        if (m_age >= RD && ((m_age - RD) % RP) == 0) sbq.push_back(cyc);
      end else begin
        m_age = 0;
      end
      m_prev = bs;
    end
    exp_held = m_acc;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_edge();
    end
  end

  bit prev_step = 1'b0;
  int exp_cyc;
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        checks++;
        if (step !== 1'b0 || held !== 1'b0) begin
          errors++;
          $display("FAIL reset_outputs cyc=%0d: step=%b held=%b, required 0/0", cyc, step, held);
        end
      end else begin
        checks++;
        if (held !== exp_held) begin
          errors++;
          $display("FAIL held cyc=%0d: got %b, required %b", cyc, held, exp_held);
        end
        if (step === 1'b1) begin
          step_cnt++;
          checks++;
          if (prev_step) begin
            errors++;
            $display("FAIL step_back_to_back cyc=%0d: step high two cycles running", cyc);
          end else if (sbq.size() == 0) begin
            errors++;
            $display("FAIL step_unexpected cyc=%0d: got step, required none", cyc);
          end else begin
            exp_cyc = sbq.pop_front();
            if (exp_cyc != cyc) begin
              errors++;
              $display("FAIL step_time: got edge %0d, required edge %0d", cyc, exp_cyc);
            end
          end
        end
      end
      prev_step = (step === 1'b1);
    end
  end

  task automatic drive(input bit b, input bit re, input int n);
    btn = b;
    repeat_en = re;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic flush(input string name);
    drive(0, 0, 40);
    check_int({name, "_pending_steps"}, sbq.size(), 0);
    check_int({name, "_held_idle"}, int'(held), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    check_int("reset_step", int'(step), 0);
    check_int("reset_held", int'(held), 0);
    reset = 1'b1;
    drive(0, 0, 10);

    // single press, no repeat
    step_cnt = 0;
    drive(1, 0, 40);
    check_int("press_held", int'(held), 1);
    flush("single_press");
    check_int("single_press_steps", step_cnt, 1);

    // short bouncy pulses never accepted
    step_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 5);
      drive(0, 0, 3);
    end
    flush("glitch_train");
    check_int("glitch_train_steps", step_cnt, 0);

    // long hold with auto-repeat
    step_cnt = 0;
    drive(1, 1, 200);
    flush("auto_repeat");
    check_int("auto_repeat_steps", step_cnt, 9);

    // release with bounces
    step_cnt = 0;
    drive(1, 0, 30);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 3);
      drive(1, 0, 3);
    end
    flush("release_bounce");
    check_int("release_bounce_steps", step_cnt, 1);

    // reset during a held press, button still high afterwards
    drive(1, 1, 40);
    reset = 1'b0;
    drive(1, 1, 10);
    reset = 1'b1;
    step_cnt = 0;
    drive(1, 0, 30);
    check_int("post_reset_steps", step_cnt, 1);
    flush("post_reset");

    // repeat_en dropped and raised mid-hold
    step_cnt = 0;
    drive(1, 1, 90);
    drive(1, 0, 50);
    drive(1, 1, 100);
    flush("repeat_gate");
    check_int("repeat_gate_steps", step_cnt, 5);

    // randomized segments against the model
    for (int i = 0; i < 80; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 4) begin
        reset = 1'b0;
        drive(1'($urandom_range(0, 1)), 1'b0, int'($urandom_range(1, 5)));
        reset = 1'b1;
      end else if (r < 20) begin
        drive(1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(60, 200)));
      end else begin
        drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(1, 25)));
      end
    end
    flush("random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
